// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, drives a 1-cycle-latency imem and buffers words in a small FIFO.
// Define FETCH_MISALIGN_CHECK_EN to halt fetch on a misaligned redirect target.
module fetch_stage #(
  parameter int                  PC_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic [31:0]         imem_rdata_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic [PC_WIDTH-1:0] pc_inced_o,
  output logic                misalign_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] inflight_pc_q;
  logic                inflight_q;
  logic [31:0]         fifo_instr_q [FIFO_DEPTH];
  logic [PC_WIDTH-1:0] fifo_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                pop;
  logic                push;
  logic                pop_eff;
  logic                fetch_en;
  logic [CNT_W:0]      occupied;
  logic [CNT_W:0]      limit;
  logic                credit_ok;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic halted_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halted_q <= 1'b0;
    end else if (redirect_i) begin
      halted_q <= (redirect_pc_i[1:0] != 2'b00);
    end
  end

  assign misalign_o = halted_q;
  assign fetch_en   = !halted_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign misalign_o           = 1'b0;
  assign fetch_en             = 1'b1;
`endif

  assign valid_o    = (count_q != '0);
  assign pop        = valid_o & ready_i;
  assign pop_eff    = pop & !redirect_i;
  assign push       = inflight_q & !redirect_i;

  // credit > 0  <=>  count + inflight < FIFO_DEPTH + pop
  assign occupied   = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign limit      = (CNT_W + 1)'(FIFO_DEPTH) + (CNT_W + 1)'(pop);
  assign credit_ok  = (occupied < limit);

  assign imem_req_o  = !rst_i & !redirect_i & fetch_en & credit_ok;
  assign imem_addr_o = pc_q;

  assign instr_o    = fifo_instr_q[rd_ptr_q];
  assign pc_o       = fifo_pc_q[rd_ptr_q];
  assign pc_inced_o = pc_o + PC_WIDTH'(4);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      inflight_q <= imem_req_o;
      if (imem_req_o) begin
        pc_q          <= pc_q + PC_WIDTH'(4);
        inflight_pc_q <= pc_q;
      end
      if (redirect_i) begin
        pc_q     <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_eff) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !pop_eff) begin
          count_q <= count_q + CNT_W'(1);
        end else if (!push && pop_eff) begin
          count_q <= count_q - CNT_W'(1);
        end
      end
    end
  end

  // Storage needs no reset: count_q gates visibility of every entry.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: imem model returns 0x1000 + (addr >> 2); outputs checked via an expected-result queue.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [15:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [15:0] redirect_pc_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] instr_o;
  logic [15:0] pc_o;
  logic [15:0] pc_inced_o;
  logic        misalign_o;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [47:0] exp_q [$];
  logic [47:0] e;

  always #5 clk_i = ~clk_i;

  fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'h0000), .FIFO_DEPTH(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_inced_o   (pc_inced_o),
    .misalign_o   (misalign_o)
  );

  // Synchronous memory: data for a request appears in the following cycle, junk otherwise.
  always @(posedge clk_i) begin
    if (imem_req_o) imem_rdata_i <= 32'h1000 + 32'(imem_addr_o >> 2);
    else            imem_rdata_i <= 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] exp_word(input logic [15:0] pc);
    return 32'h1000 + 32'(pc[15:2]);
  endfunction

  task automatic push_seq(input logic [15:0] start, input int n);
    logic [15:0] p;
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({exp_word(p), p});
      p = p + 16'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 16'h0000; ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (valid_o !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b, expected 0", valid_o); end
    n_checks++;
    if (imem_req_o !== 1'b0) begin n_fails++; $display("FAIL reset_req: got %b, expected 0", imem_req_o); end
    n_checks++;
    if (misalign_o !== 1'b0) begin n_fails++; $display("FAIL reset_misalign: got %b, expected 0", misalign_o); end
  endtask

  task automatic test_stream();
    do_reset();
    push_seq(16'h0000, 10);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      rst_i = 1'b0; ready_i = 1'b1;
      #1;
      if (c == 0) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
          n_fails++; $display("FAIL stream_first_req: got req %b addr %h, expected 1 0000", imem_req_o, imem_addr_o);
        end
      end
      if (c == 1 || c == 2) begin
        n_checks++;
        if (valid_o !== (c == 2)) begin
          n_fails++; $display("FAIL stream_latency: cycle %0d valid %b, expected %b", c, valid_o, (c == 2));
        end
      end
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL stream_extra: got pc %h, expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({instr_o, pc_o, pc_inced_o} !== {e[47:16], e[15:0], e[15:0] + 16'd4}) begin
            n_fails++; $display("FAIL stream_data: got %h/%h/%h, expected %h/%h/%h", instr_o, pc_o, pc_inced_o, e[47:16], e[15:0], e[15:0] + 16'd4);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL stream_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    do_reset();
    push_seq(16'h0000, 6);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      rst_i = 1'b0; ready_i = (c >= 6);
      #1;
      if (c >= 2 && c < 6) begin
        n_checks++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 16'h0008) begin
          n_fails++; $display("FAIL stall_hold_req: cycle %0d req %b addr %h, expected 0 0008", c, imem_req_o, imem_addr_o);
        end
        n_checks++;
        if (valid_o !== 1'b1 || pc_o !== 16'h0000 || instr_o !== 32'h1000) begin
          n_fails++; $display("FAIL stall_hold_head: cycle %0d valid %b pc %h instr %h, expected 1 0000 00001000", c, valid_o, pc_o, instr_o);
        end
      end
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL stall_extra: got pc %h, expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({instr_o, pc_o, pc_inced_o} !== {e[47:16], e[15:0], e[15:0] + 16'd4}) begin
            n_fails++; $display("FAIL stall_data: got %h/%h/%h, expected %h/%h/%h", instr_o, pc_o, pc_inced_o, e[47:16], e[15:0], e[15:0] + 16'd4);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL stall_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    push_seq(16'h0040, 5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      rst_i = 1'b0; redirect_i = (c == 2); redirect_pc_i = 16'h0040; ready_i = (c >= 3);
      #1;
      if (c == 2) begin
        n_checks++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b1) begin
          n_fails++; $display("FAIL redir_cycle: req %b valid %b, expected 0 1", imem_req_o, valid_o);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0040) begin
          n_fails++; $display("FAIL redir_next: valid %b req %b addr %h, expected 0 1 0040", valid_o, imem_req_o, imem_addr_o);
        end
      end
      if (c == 4 || c == 5) begin
        n_checks++;
        if (valid_o !== (c == 5)) begin
          n_fails++; $display("FAIL redir_latency: cycle %0d valid %b, expected %b", c, valid_o, (c == 5));
        end
      end
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL redir_extra: got pc %h, expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({instr_o, pc_o, pc_inced_o} !== {e[47:16], e[15:0], e[15:0] + 16'd4}) begin
            n_fails++; $display("FAIL redir_data: got %h/%h/%h, expected %h/%h/%h", instr_o, pc_o, pc_inced_o, e[47:16], e[15:0], e[15:0] + 16'd4);
          end
        end
      end
    end
    redirect_i = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL redir_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    do_reset();
    push_seq(16'hFFFC, 4);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk_i);
      rst_i = 1'b0; redirect_i = (c == 0); redirect_pc_i = 16'hFFFC; ready_i = (c >= 1);
      #1;
      if (c == 1) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'hFFFC) begin
          n_fails++; $display("FAIL wrap_req: req %b addr %h, expected 1 fffc", imem_req_o, imem_addr_o);
        end
      end
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL wrap_extra: got pc %h, expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({instr_o, pc_o, pc_inced_o} !== {e[47:16], e[15:0], e[15:0] + 16'd4}) begin
            n_fails++; $display("FAIL wrap_data: got %h/%h/%h, expected %h/%h/%h", instr_o, pc_o, pc_inced_o, e[47:16], e[15:0], e[15:0] + 16'd4);
          end
        end
      end
    end
    redirect_i = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL wrap_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_seq(16'h0200, 4);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      rst_i = 1'b0;
      redirect_i    = (c == 2 || c == 3);
      redirect_pc_i = (c == 2) ? 16'h0100 : 16'h0200;
      ready_i       = !(c == 2 || c == 3);
      #1;
      if (c == 3) begin
        n_checks++;
        if (imem_req_o !== 1'b0) begin n_fails++; $display("FAIL b2b_cancel: req %b, expected 0", imem_req_o); end
      end
      if (c == 4) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 16'h0200 || valid_o !== 1'b0) begin
          n_fails++; $display("FAIL b2b_target: req %b addr %h valid %b, expected 1 0200 0", imem_req_o, imem_addr_o, valid_o);
        end
      end
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL b2b_extra: got pc %h, expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({instr_o, pc_o, pc_inced_o} !== {e[47:16], e[15:0], e[15:0] + 16'd4}) begin
            n_fails++; $display("FAIL b2b_data: got %h/%h/%h, expected %h/%h/%h", instr_o, pc_o, pc_inced_o, e[47:16], e[15:0], e[15:0] + 16'd4);
          end
        end
      end
    end
    redirect_i = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL b2b_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_misalign();
    do_reset();
`ifdef FETCH_MISALIGN_CHECK_EN
    push_seq(16'h0080, 3);
`else
    push_seq(16'h0040, 9);
`endif
    for (int c = 0; c < 14; c++) begin
      @(negedge clk_i);
      rst_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_i    = (c == 2 || c == 8);
      redirect_pc_i = (c == 2) ? 16'h0042 : 16'h0080;
`else
      redirect_i    = (c == 2);
      redirect_pc_i = 16'h0042;
`endif
      ready_i = !redirect_i;
      #1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (c >= 3 && c <= 8) begin
        n_checks++;
        if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
          n_fails++; $display("FAIL misalign_halt: cycle %0d misalign %b req %b valid %b, expected 1 0 0", c, misalign_o, imem_req_o, valid_o);
        end
      end
      if (c == 9) begin
        n_checks++;
        if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0080) begin
          n_fails++; $display("FAIL misalign_resume: misalign %b req %b addr %h, expected 0 1 0080", misalign_o, imem_req_o, imem_addr_o);
        end
      end
`else
      if (c == 3) begin
        n_checks++;
        if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0040) begin
          n_fails++; $display("FAIL misalign_ignored: misalign %b req %b addr %h, expected 0 1 0040", misalign_o, imem_req_o, imem_addr_o);
        end
      end
`endif
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL misalign_extra: got pc %h, expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({instr_o, pc_o, pc_inced_o} !== {e[47:16], e[15:0], e[15:0] + 16'd4}) begin
            n_fails++; $display("FAIL misalign_data: got %h/%h/%h, expected %h/%h/%h", instr_o, pc_o, pc_inced_o, e[47:16], e[15:0], e[15:0] + 16'd4);
          end
        end
      end
    end
    redirect_i = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL misalign_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push_seq(16'h0000, 5);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      rst_i = (c == 4); ready_i = (c >= 5);
      #1;
      if (c == 3) begin
        n_checks++;
        if (valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
          n_fails++; $display("FAIL rstmid_full: valid %b req %b, expected 1 0", valid_o, imem_req_o);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 16'h0000) begin
          n_fails++; $display("FAIL rstmid_restart: valid %b req %b addr %h, expected 0 1 0000", valid_o, imem_req_o, imem_addr_o);
        end
      end
      if (c == 6) begin
        n_checks++;
        if (valid_o !== 1'b0) begin n_fails++; $display("FAIL rstmid_stale: valid %b, expected 0", valid_o); end
      end
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++; $display("FAIL rstmid_extra: got pc %h, expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({instr_o, pc_o, pc_inced_o} !== {e[47:16], e[15:0], e[15:0] + 16'd4}) begin
            n_fails++; $display("FAIL rstmid_data: got %h/%h/%h, expected %h/%h/%h", instr_o, pc_o, pc_inced_o, e[47:16], e[15:0], e[15:0] + 16'd4);
          end
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fails++; $display("FAIL rstmid_drain: %0d left, expected 0", exp_q.size()); end
  endtask

  initial begin
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 16'h0000; ready_i = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_wrap();
    test_back_to_back();
    test_misalign();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
